// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared redirect/state types and default vectors for the fetch PC unit
package mips_pkg;

  // Numeric encoding doubles as arbitration priority (higher wins)
  typedef enum logic [2:0] {
    RC_NONE   = 3'd0,
    RC_BRANCH = 3'd1,
    RC_JUMP   = 3'd2,
    RC_ERET   = 3'd3,
    RC_EXC    = 3'd4
  } redir_class_e;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0028;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
  localparam int          DEF_INC          = 4;

  // True when candidate class a should displace incumbent class b (ties go to a)
  function automatic logic prio_ge(input redir_class_e a, input redir_class_e b);
    return logic'(a >= b);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// rtl/pc_redirect_arb.sv - priority and alignment selector for PC redirect requests
module pc_redirect_arb
  import mips_pkg::*;
#(
  parameter int                 WIDTH      = 32,
  parameter logic [WIDTH-1:0]   EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic                i_exc,
  input  logic                i_eret,
  input  logic                i_jump,
  input  logic                i_branch,
  input  logic [WIDTH-1:0]    i_eret_target,
  input  logic [WIDTH-1:0]    i_jump_target,
  input  logic [WIDTH-1:0]    i_branch_target,
  input  redir_class_e        i_base_class,
  input  logic [WIDTH-1:0]    i_base_target,
  output redir_class_e        o_class,
  output logic [WIDTH-1:0]    o_target
);

  redir_class_e     w_req_class;
  logic [WIDTH-1:0] w_req_target;

  // Pick the highest-priority request; misaligned jump/branch targets turn into exceptions
  always_comb begin
    w_req_class  = RC_NONE;
    w_req_target = '0;
    if (i_exc) begin
      w_req_class  = RC_EXC;
      w_req_target = EXC_VECTOR;
    end else if (i_eret) begin
      w_req_class  = RC_ERET;
      w_req_target = i_eret_target;
    end else if (i_jump) begin
      if (i_jump_target[1:0] != 2'b00) begin
        w_req_class  = RC_EXC;
        w_req_target = EXC_VECTOR;
      end else begin
        w_req_class  = RC_JUMP;
        w_req_target = i_jump_target;
      end
    end else if (i_branch) begin
      if (i_branch_target[1:0] != 2'b00) begin
        w_req_class  = RC_EXC;
        w_req_target = EXC_VECTOR;
      end else begin
        w_req_class  = RC_BRANCH;
        w_req_target = i_branch_target;
      end
    end
  end

  // Requests beat the base candidate unless the base is strictly higher priority
  always_comb begin
    o_class  = i_base_class;
    o_target = i_base_target;
    if (prio_ge(w_req_class, i_base_class)) begin
      o_class  = w_req_class;
      o_target = w_req_target;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with stall-buffered redirects, halt and EPC
module pc_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int               INC          = DEF_INC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_i,
  input  logic             eret_i,
  input  logic             halt_i,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             halted
);

  pc_state_e        r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  redir_class_e     r_pend_class;
  logic [WIDTH-1:0] r_pend_target;

  redir_class_e     w_new_class;
  logic [WIDTH-1:0] w_new_target;
  redir_class_e     w_sel_class;
  logic [WIDTH-1:0] w_sel_target;
  logic             w_new_exc_saves_epc;

  // Winner among this cycle's raw inputs only
  pc_redirect_arb #(.WIDTH(WIDTH), .EXC_VECTOR(EXC_VECTOR)) u_new_arb (
    .i_exc           (exc_i),
    .i_eret          (eret_i),
    .i_jump          (jump_i),
    .i_branch        (branch_i),
    .i_eret_target   (r_epc),
    .i_jump_target   (jump_target),
    .i_branch_target (branch_target),
    .i_base_class    (RC_NONE),
    .i_base_target   ('0),
    .o_class         (w_new_class),
    .o_target        (w_new_target)
  );

  // Merge the new winner against the buffered redirect; ties favour the new one
  pc_redirect_arb #(.WIDTH(WIDTH), .EXC_VECTOR(EXC_VECTOR)) u_merge_arb (
    .i_exc           (w_new_class == RC_EXC),
    .i_eret          (w_new_class == RC_ERET),
    .i_jump          (w_new_class == RC_JUMP),
    .i_branch        (w_new_class == RC_BRANCH),
    .i_eret_target   (w_new_target),
    .i_jump_target   (w_new_target),
    .i_branch_target (w_new_target),
    .i_base_class    (r_pend_class),
    .i_base_target   (r_pend_target),
    .o_class         (w_sel_class),
    .o_target        (w_sel_target)
  );

  // A fresh exception records epc unless one is already buffered (its epc is already saved)
  assign w_new_exc_saves_epc = (w_new_class == RC_EXC) && (r_pend_class != RC_EXC);

  assign pc       = r_pc;
  assign pc_plus4 = r_pc + WIDTH'(INC);
  assign epc      = r_epc;
  assign pc_valid = (r_state == ST_RUN) && !stall_i;
  assign halted   = (r_state == ST_HALTED);

  // Fetch state machine: PC update, redirect buffering during stalls, halt and EPC capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR;
      r_epc         <= '0;
      r_pend_class  <= RC_NONE;
      r_pend_target <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_new_exc_saves_epc) begin
            r_epc <= r_pc;
          end
          if (stall_i) begin
            if (w_sel_class != RC_NONE) begin
              r_pend_class  <= w_sel_class;
              r_pend_target <= w_sel_target;
            end
          end else begin
            r_pend_class  <= RC_NONE;
            r_pend_target <= '0;
            if (halt_i && (w_sel_class != RC_EXC)) begin
              r_state <= ST_HALTED;
            end else if (w_sel_class == RC_NONE) begin
              r_pc <= pc_plus4;
            end else begin
              r_pc <= w_sel_target;
            end
          end
        end
        ST_HALTED: begin
          if (exc_i) begin
            r_state <= ST_RUN;
            r_pc    <= EXC_VECTOR;
            r_epc   <= r_pc;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule
